// File: rtl/pc_seq_unit.sv
// Program-counter unit: next-PC select, alignment, stall
// and a small circular return-address stack.
module pc_seq_unit #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter int               STEP      = 4,
  parameter int               RAS_DEPTH = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Stall,
  input  logic [1:0]       Sel,
  input  logic [WIDTH-1:0] BranchOff,
  input  logic [WIDTH-1:0] JumpTarget,
  input  logic [WIDTH-1:0] RegTarget,
  input  logic             Call,
  input  logic             Ret,
  output logic [WIDTH-1:0] Address,
  output logic [WIDTH-1:0] AddressPlus,
  output logic             Misalign,
  output logic             RasEmpty,
  output logic             RasFull
);

  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'(STEP - 1);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(RAS_DEPTH);
  localparam logic [PW:0] ONE_CNT = (PW + 1)'(1);
  localparam logic [PW-1:0] ONE_PTR = PW'(1);

  logic [WIDTH-1:0] ras [RAS_DEPTH];
  logic [PW-1:0]    ptr;
  logic [PW:0]      cnt;

  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] next_addr;
  logic             next_mis;
  logic             pop;
  logic             wr_en;
  logic [PW-1:0]    wr_idx;
  logic [PW-1:0]    next_ptr;
  logic [PW:0]      next_cnt;

  assign AddressPlus = Address + STEP_W;
  assign RasEmpty = (cnt == '0);
  assign RasFull = (cnt == FULL_CNT);
  assign pop = Ret && (Sel == 2'b11) && !RasEmpty;

  // Select the raw target and strip the alignment bits.
  always_comb begin
    raw = AddressPlus;
    unique case (1'b1)
      (Sel == 2'b00): raw = AddressPlus;
      (Sel == 2'b01): raw = Address + BranchOff;
      (Sel == 2'b10): raw = JumpTarget;
      (Sel == 2'b11): raw = pop ? ras[ptr] : RegTarget;
    endcase
    next_addr = raw & ~LOW_MASK;
    next_mis = (Sel != 2'b00) && (|(raw & LOW_MASK));
  end

  // RAS pointer/count update; a call+return replaces the top.
  always_comb begin
    wr_en = Call;
    wr_idx = ptr + ONE_PTR;
    next_ptr = ptr;
    next_cnt = cnt;
    if (Call && pop) begin
      wr_idx = ptr;
    end else if (Call) begin
      next_ptr = ptr + ONE_PTR;
      next_cnt = RasFull ? cnt : cnt + ONE_CNT;
    end else if (pop) begin
      next_ptr = ptr - ONE_PTR;
      next_cnt = cnt - ONE_CNT;
    end
  end

  // PC, misalign flag and RAS bookkeeping registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Address <= RESET_VEC;
      Misalign <= 1'b0;
      ptr <= '0;
      cnt <= '0;
    end else if (!Stall) begin
      Address <= next_addr;
      Misalign <= next_mis;
      ptr <= next_ptr;
      cnt <= next_cnt;
    end
  end

  // RAS storage; contents need no reset.
  always_ff @(posedge Clk) begin
    if (!Reset && !Stall && wr_en) begin
      ras[wr_idx] <= AddressPlus;
    end
  end

endmodule

// File: doc/pc_seq_unit.md
# pc_seq_unit

Parametrised program-counter unit for the single-cycle CPU datapath. It holds the current fetch address and selects the next one: sequential, PC-relative branch, absolute jump, or register jump/return. Over a plain PC register with an external adder it adds stall/hold, alignment enforcement and a small circular return-address stack (RAS). It drives the instruction-memory address and provides the link value (PC+STEP) to the register-file write-back mux.

## Interface
Parameters:
- WIDTH, 32, address width in bits
- RESET_VEC, 0, address loaded on reset
- STEP, 4, bytes per instruction; power of two, ≥1; ALIGN = log2(STEP)
- RAS_DEPTH, 4, return-address stack entries; power of two, ≥2

Ports:
- Clk  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- Stall  in  1  hold PC and RAS this cycle
- Sel  in  2  next-PC source: 00 sequential, 01 branch, 10 jump absolute, 11 jump register/return
- BranchOff  in  WIDTH  signed byte offset for Sel=01
- JumpTarget  in  WIDTH  absolute target for Sel=10
- RegTarget  in  WIDTH  register target for Sel=11
- Call  in  1  push PC+STEP onto RAS
- Ret  in  1  with Sel=11, pop RAS and use it as target
- Address  out  WIDTH  current PC (registered)
- AddressPlus  out  WIDTH  Address+STEP, combinational
- Misalign  out  1  registered; last loaded target had nonzero low ALIGN bits
- RasEmpty  out  1  RAS count = 0
- RasFull  out  1  RAS count = RAS_DEPTH

## Operation
- Raw target: 00 → Address+STEP; 01 → Address+BranchOff; 10 → JumpTarget; 11 → RAS top if Ret and not RasEmpty, else RegTarget.
- All additions are modulo 2^WIDTH; wrap-around is silent.
- Next Address = raw target with low ALIGN bits forced to 0. Misalign <= OR of those raw low bits. The sequential path never sets Misalign.
- RAS: circular array, top pointer, count 0..RAS_DEPTH.
  - Call pushes AddressPlus. When full, it overwrites the oldest entry and count stays at RAS_DEPTH.
  - Ret pops only when Sel=11 and count>0. Ret with Sel≠11 is ignored. Ret when empty falls back to RegTarget and leaves the RAS unchanged.
  - Call and Ret together with Sel=11: the pop provides the target, then the push replaces the top. Net count is unchanged.
- Stall=1: Address, Misalign and RAS all hold. Call and Ret are ignored. AddressPlus still tracks Address.
- Reset asserted at any time, including mid-stall: Address=RESET_VEC, Misalign=0, count=0, pointer=0, RasEmpty=1, RasFull=0. RAS array contents are don't-care.

## Timing
- Single-cycle: the selected target appears on Address after the next rising Clk edge. Load latency is 1 cycle.
- Sel, offsets, targets, Call and Ret are sampled only at the rising edge and must be stable in setup.
- RasEmpty and RasFull are registered-state derived. They reflect the count after the last edge.
- Reset is asynchronous assert. Deassertion is synchronised outside this block. The first update occurs at the first rising edge with Reset=0.
- No handshake. The block accepts one control set per non-stalled cycle.

## Test plan
- Reset with RESET_VEC=0x100 → Address=0x100, Misalign=0, RasEmpty=1. Three cycles with Sel=00 → 0x104, 0x108, 0x10C.
- Branch at Address=0x200: BranchOff=0xFFFFFFF0 → 0x1F0; BranchOff=0x7 → 0x204 with Misalign=1. Next Sel=00 clears Misalign.
- Call/return: at 0x40, Sel=10, JumpTarget=0x800, Call=1 → Address=0x800, RAS top=0x44. Later Sel=11, Ret=1, RegTarget=0x999 → Address=0x44, RasEmpty=1.
- RAS overflow with RAS_DEPTH=4: five Calls from 0x0,0x10,0x20,0x30,0x40 → RasFull=1. Five Rets return 0x44,0x34,0x24,0x14, then RegTarget, because the oldest entry was overwritten.
- Stall: Stall=1 for 3 cycles with Sel=10 and Call=1 → Address and RAS count unchanged. Release → jump taken once.
- Async Reset mid-stream at Address=0xFFFFFFFC (WIDTH=32, Sel=00 would wrap to 0x0): Reset pulse between edges → Address=RESET_VEC immediately, RAS emptied. Without reset, the wrap to 0x0 is verified separately.
